// File: rtl/da_coef_loader_if.sv
// Coefficient stream and SRAM coefficient-load port of the DA table loader.
// The loader side is the master: it drives the SRAM writes and the ready.
interface da_coef_loader_if #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 20
);
    logic                     coef_valid;
    logic                     coef_ready;
    logic signed [COEF_W-1:0] coef_data;
    logic                     CLOAD;
    logic [10:0]              CADDR;
    logic [DATA_W-1:0]        CIN;

    modport master (
        input  coef_valid,
        input  coef_data,
        output coef_ready,
        output CLOAD,
        output CADDR,
        output CIN
    );

    modport slave (
        output coef_valid,
        output coef_data,
        input  coef_ready,
        input  CLOAD,
        input  CADDR,
        input  CIN
    );
endinterface

// File: rtl/da_coef_loader.sv
// da_coef_loader: collects 8 taps per bank from the coefficient stream and
// writes all 256 partial sums of each bank into the coefficient SRAM, walking
// entries in Gray-code order so each new entry is one add or subtract away.
module da_coef_loader #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_start,
    output logic             busy,
    output logic             done,
    da_coef_loader_if.master bus
);
    localparam int ACC_W = COEF_W + 3;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [2:0]               r_bank;
    logic [2:0]               w_nextBank;
    logic [2:0]               r_tap;
    logic [2:0]               w_nextTap;
    logic [7:0]               r_i;
    logic [7:0]               w_nextI;
    logic signed [ACC_W-1:0]  r_sum;
    logic signed [ACC_W-1:0]  w_nextSum;
    logic signed [COEF_W-1:0] r_c [8];
    logic                     w_store;

    logic [7:0]               w_iInc;
    logic [7:0]               w_grayInc;
    logic [7:0]               w_nextGray;
    logic [2:0]               w_k;
    logic signed [ACC_W-1:0]  w_term;

    logic                     r_cload;
    logic [10:0]              r_caddr;
    logic [DATA_W-1:0]        r_cin;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;

    function automatic logic [2:0] trailingZeros(input logic [7:0] v);
        logic [2:0] k;
        k = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (v[j]) k = 3'(j);
        end
        return k;
    endfunction

    // Moving from Gray entry g(i) to g(i+1) flips exactly bit k = ctz(i+1).
    assign w_iInc     = r_i + 8'd1;
    assign w_grayInc  = w_iInc ^ (w_iInc >> 1);
    assign w_k        = trailingZeros(w_iInc);
    assign w_term     = ACC_W'(r_c[w_k]);
    assign w_nextGray = w_nextI ^ (w_nextI >> 1);

    // Next-state logic: tap collection, per-entry sum update, bank sequencing.
    always_comb begin
        w_nextState = r_state;
        w_nextBank  = r_bank;
        w_nextTap   = r_tap;
        w_nextI     = r_i;
        w_nextSum   = r_sum;
        w_store     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_nextState = LOAD;
                    w_nextBank  = 3'd0;
                    w_nextTap   = 3'd0;
                end
            end
            LOAD: begin
                if (bus.coef_valid) begin
                    w_store   = 1'b1;
                    w_nextTap = r_tap + 3'd1;
                    if (r_tap == 3'd7) begin
                        w_nextState = WRITE;
                        w_nextTap   = 3'd0;
                        w_nextI     = 8'd0;
                        w_nextSum   = '0;
                    end
                end
            end
            WRITE: begin
                if (r_i == 8'hFF) begin
                    if (r_bank != 3'd7) begin
                        w_nextState = LOAD;
                        w_nextBank  = r_bank + 3'd1;
                        w_nextTap   = 3'd0;
                    end else begin
                        w_nextState = DONE;
                    end
                end else begin
                    w_nextI = w_iInc;
                    if (w_grayInc[w_k]) w_nextSum = r_sum + w_term;
                    else                w_nextSum = r_sum - w_term;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, coefficient store and registered outputs derived from next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_bank  <= 3'd0;
            r_tap   <= 3'd0;
            r_i     <= 8'd0;
            r_sum   <= '0;
            for (int n = 0; n < 8; n++) r_c[n] <= '0;
            r_cload <= 1'b0;
            r_caddr <= 11'd0;
            r_cin   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_bank  <= w_nextBank;
            r_tap   <= w_nextTap;
            r_i     <= w_nextI;
            r_sum   <= w_nextSum;
            if (w_store) r_c[r_tap] <= bus.coef_data;
            r_cload <= (w_nextState == WRITE);
            if (w_nextState == WRITE) begin
                r_caddr <= {w_nextBank, w_nextGray};
                r_cin   <= DATA_W'(w_nextSum);
            end
            r_ready <= (w_nextState == LOAD);
            r_busy  <= (w_nextState != IDLE);
            r_done  <= (w_nextState == DONE);
        end
    end

    assign bus.CLOAD      = r_cload;
    assign bus.CADDR      = r_caddr;
    assign bus.CIN        = r_cin;
    assign bus.coef_ready = r_ready;
    assign busy           = r_busy;
    assign done           = r_done;
endmodule

// File: doc/da_coef_loader.md
# da_coef_loader

Builds the distributed-arithmetic lookup tables for the FIR datapath from a stream of raw filter coefficients and writes them into the 8-bank coefficient SRAM through the datapath's coefficient-load port (CLOAD/CADDR/CIN). For each bank the block generates all 256 partial sums of that bank's 8 taps, using Gray-code address order so that each entry costs one add or subtract. It sits between the host configuration interface and the DA datapath, and is the only writer of the ROM bank.

## Interface
- COEF_W, 16, signed coefficient width; COEF_W+3 <= DATA_W is required.
- DATA_W, 20, SRAM word width (CIN width).
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cfg_start  in  1  one-cycle pulse; begins a full 64-coefficient table build
- coef_valid  in  1  coef_data valid
- coef_ready  out  1  block accepts a coefficient this cycle
- coef_data  in  COEF_W  signed coefficient, tap order 0..63
- CLOAD  out  1  SRAM write strobe, one write per high cycle
- CADDR  out  11  {bank[2:0], entry[7:0]}
- CIN  out  DATA_W  LUT entry, sign-extended partial sum
- busy  out  1  build in progress
- done  out  1  one-cycle pulse after the final write

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: coef_ready=0, CLOAD=0. cfg_start=1 -> LOAD, bank=0, tap count=0. cfg_start is ignored in all other states.
- LOAD: coef_ready=1. On each valid&ready handshake, store coef_data in c[tap], then increment tap. The bank maps to taps 8*bank .. 8*bank+7, and c[k] is local tap k. After the 8th handshake (tap==7) -> WRITE, i=0, sum=0.
- WRITE: one SRAM write every cycle for i = 0..255. The block drives:
  - CLOAD=1
  - CADDR={bank, g(i)}, where g(i) = i ^ (i>>1)
  - CIN = sign-extend(sum_i) to DATA_W
- Sum update per cycle: sum_{i+1} = sum_i ± c[k], where k = trailing-zero count of (i+1). Add if bit k of g(i+1) is 1, subtract otherwise.
- Invariant: CIN at entry address a equals Σ c[k] over the set bits k of a, so entry 0 is always 0.
- At i==255:
  - bank<7: -> LOAD, bank+1, tap=0.
  - bank==7: -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- Accumulator width: COEF_W+3 bits signed. It cannot overflow, because at most 8 terms are summed.
- busy=1 in LOAD, WRITE and DONE.
- coef_data arriving while coef_ready=0 is not consumed; the source holds it.

## Timing
- Reset (resetn=0 at a clk edge): next state is IDLE. Outputs go to CLOAD=0, CADDR=0, CIN=0, coef_ready=0, busy=0, done=0. bank, tap, i and sum are cleared.
- Reset mid-build aborts immediately. The SRAM is left partially written, and a new cfg_start is needed.
- All outputs are registered. CLOAD, CADDR and CIN change only on clk edges and are stable for a full cycle, which satisfies the SRAM setup/hold requirement.
- The cycle after the 8th handshake of a bank, CLOAD=1 with entry 0.
- Each bank produces exactly 256 consecutive CLOAD cycles with no gaps.
- coef_ready rises the cycle after the final write of banks 0..6.
- done rises the cycle after the final write of bank 7.
- Minimum build time with coef_valid held high: 8*(8+256)+2 cycles from cfg_start to done.
- The handshake is backpressure-free within WRITE: coef_ready=0 for all 256 cycles.

## Test plan
- All 64 coefficients = 1:
  - every write has CIN = popcount(CADDR[7:0]), e.g. entry 0xFF -> 8;
  - exactly 2048 CLOAD cycles;
  - done one cycle after the last write.
- Bank 0 has only c[3]=-5, others 0:
  - entries with bit 3 set -> CIN=0xFFFFB, all others 0;
  - write order for bank 0 is 0x000, 0x001, 0x003, 0x002, 0x006, ...
- All coefficients = -32768:
  - entry 0xFF -> CIN=0xC0000;
  - entry 0x01 -> CIN=0xF8000.
- coef_valid toggles 1/0 with random gaps:
  - no coefficient is lost or duplicated;
  - LUT contents are identical to the no-gap run.
- resetn=0 during bank 3 WRITE at i=100:
  - CLOAD=0 and busy=0 the next cycle;
  - a following cfg_start rebuilds correctly from bank 0.
- cfg_start pulsed during WRITE: no state change, and the write sequence is unchanged.
